// File: rtl/bcd_seg_scan_if.sv
// Bundle between the BCD converter side and the 7-segment scan driver.
//   tran_done          1-cycle strobe, the digit fields are valid this cycle
//   thou/hund/tens/unit_data  BCD digits
//   dp_en              decimal point per digit, [3]=thou .. [0]=unit
//   lz_blank           1: blank leading zeros
//   seg                {dp,g,f,e,d,c,b,a}, driver output
//   sel                digit enable, [3]=thou .. [0]=unit, driver output
// master: the side that supplies digits and observes the display.
// slave : the scan driver.
interface bcd_seg_scan_if;
  logic       tran_done;
  logic [3:0] thou_data;
  logic [3:0] hund_data;
  logic [3:0] tens_data;
  logic [3:0] unit_data;
  logic [3:0] dp_en;
  logic       lz_blank;
  logic [7:0] seg;
  logic [3:0] sel;

  modport master (
    output tran_done, thou_data, hund_data, tens_data, unit_data, dp_en, lz_blank,
    input  seg, sel
  );

  modport slave (
    input  tran_done, thou_data, hund_data, tens_data, unit_data, dp_en, lz_blank,
    output seg, sel
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Multiplexed 4-digit 7-segment driver for a common-segment display.
// Digits are captured on tran_done and scanned one per slot of SCAN_DIV
// cycles (unit, tens, hund, thou). Each slot begins with BLANK_CYC cycles
// with every select off to stop ghosting between digits.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of bcd_seg_scan_if (digits, dp_en, lz_blank in; seg, sel out)
module bcd_seg_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_seg_scan_if.slave bus
);

  localparam int         CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? 4'hF  : 4'h0;

  logic [CW-1:0]   scan_cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] in_dig;    // [3]=thou .. [0]=unit
  logic [3:0][3:0] latch_dig; // last captured value
  logic [3:0][3:0] show_dig;  // value frozen for the current slot
  logic            wrap;
  logic [3:0]      cur;
  logic [6:0]      dec;
  logic            lead_zero;
  logic [7:0]      seg_n;
  logic [3:0]      sel_n;

  assign in_dig = {bus.thou_data, bus.hund_data, bus.tens_data, bus.unit_data};
  assign wrap   = (scan_cnt == CW'(SCAN_DIV - 1));
  assign cur    = show_dig[idx];

  always_comb begin
    dec = 7'h40; // invalid BCD shows a dash
    case (cur)
      4'd0: dec = 7'h3F;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5B;
      4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6D;
      4'd6: dec = 7'h7D;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  end

  // A digit is a leading zero when it and every more-significant digit are 0.
  // Invalid digits are non-zero here, and the unit digit is never blanked.
  always_comb begin
    lead_zero = 1'b0;
    case (idx)
      2'd3: lead_zero = (show_dig[3] == 4'd0);
      2'd2: lead_zero = (show_dig[3] == 4'd0) && (show_dig[2] == 4'd0);
      2'd1: lead_zero = (show_dig[3] == 4'd0) && (show_dig[2] == 4'd0) &&
                        (show_dig[1] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
    lead_zero = lead_zero && bus.lz_blank;
  end

  // Active-high view of the next output; polarity is applied at the register.
  always_comb begin
    seg_n = {bus.dp_en[idx], lead_zero ? 7'h00 : dec};
    sel_n = 4'b0001 << idx;
    if (scan_cnt < CW'(BLANK_CYC)) begin
      seg_n = 8'h00;
      sel_n = 4'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      latch_dig <= '0;
      show_dig  <= '0;
      bus.seg   <= SEG_OFF;
      bus.sel   <= SEL_OFF;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + CW'(1);
      if (wrap) idx <= idx + 2'd1;
      if (bus.tran_done) latch_dig <= in_dig;
      // Slot boundary freezes the digits; a capture on the same edge wins.
      if (wrap) show_dig <= bus.tran_done ? in_dig : latch_dig;
      bus.seg <= (SEG_ACTIVE_LOW != 0) ? ~seg_n : seg_n;
      bus.sel <= (SEL_ACTIVE_LOW != 0) ? ~sel_n : sel_n;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;
  localparam int DIV = 8;
  localparam int BLK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tran_done = 1'b0;
  logic [3:0] thou = 4'd0, hund = 4'd0, tens = 4'd0, unit = 4'd0, dp_en = 4'd0;
  logic       lz = 1'b0;

  bcd_seg_scan_if ifa ();
  bcd_seg_scan_if ifb ();

  assign ifa.tran_done = tran_done;
  assign ifa.thou_data = thou;
  assign ifa.hund_data = hund;
  assign ifa.tens_data = tens;
  assign ifa.unit_data = unit;
  assign ifa.dp_en     = dp_en;
  assign ifa.lz_blank  = lz;
  assign ifb.tran_done = tran_done;
  assign ifb.thou_data = thou;
  assign ifb.hund_data = hund;
  assign ifb.tens_data = tens;
  assign ifb.unit_data = unit;
  assign ifb.dp_en     = dp_en;
  assign ifb.lz_blank  = lz;

  // active-low display
  bcd_seg_scan #(.SCAN_DIV(DIV), .BLANK_CYC(BLK), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1))
    u_lo (.clk(clk), .rst_n(rst_n), .bus(ifa));
  // active-high display
  bcd_seg_scan #(.SCAN_DIV(DIV), .BLANK_CYC(BLK), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0))
    u_hi (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_chk = 0;
  int n_fail = 0;
  int j = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B;
      4'd3: return 7'h4F; 4'd4: return 7'h66; 4'd5: return 7'h6D;
      4'd6: return 7'h7D; 4'd7: return 7'h07; 4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Active-high {seg, sel} for the n-th clock edge after reset release.
  function automatic logic [11:0] model_out(input logic [3:0][3:0] d, input int n,
                                            input logic [3:0] dpe, input logic lzb);
    int idx;
    int cnt;
    logic lead;
    logic [7:0] s;
    logic [3:0] e;
    idx = (n / DIV) % 4;
    cnt = n % DIV;
    if (cnt < BLK) return 12'h000;
    lead = lzb && (idx != 0);
    for (int k = 3; k >= idx; k--) if (d[k] != 4'd0) lead = 1'b0;
    s = {dpe[idx], lead ? 7'h00 : dec(d[idx])};
    e = 4'b0001 << idx;
    return {s, e};
  endfunction

  int              m_n;
  logic [3:0][3:0] m_latch, m_show;
  logic [11:0]     x;

  // Digits shown in a slot are those captured up to and including the
  // edge that starts it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n     <= 0;
      m_latch <= '0;
      m_show  <= '0;
      x       <= 12'h000;
    end else begin
      x <= model_out(m_show, m_n, dp_en, lz);
      if (tran_done) m_latch <= {thou, hund, tens, unit};
      if (m_n % DIV == DIV - 1)
        m_show <= tran_done ? {thou, hund, tens, unit} : m_latch;
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    check("seg_lo", ifa.seg, ~x[11:4]);
    check("sel_lo", {4'h0, ifa.sel}, {4'h0, ~x[3:0]});
    check("seg_hi", ifb.seg, x[11:4]);
    check("sel_hi", {4'h0, ifb.sel}, {4'h0, x[3:0]});
  end

  // ---------------- stimulus ----------------
  task automatic step(input int k);
    repeat (k) begin @(negedge clk); j++; end
  endtask

  task automatic goto_j(input int t);
    while (j < t) step(1);
  endtask

  task automatic lit(input string name, input logic [7:0] s, input logic [3:0] e);
    check({name, "_seg"}, ifa.seg, s);
    check({name, "_sel"}, {4'h0, ifa.sel}, {4'h0, e});
  endtask

  task automatic pulse(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    {thou, hund, tens, unit} = {a, b, c, d};
    tran_done = 1'b1;
    step(1);
    tran_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    lit("rst", 8'hFF, 4'hF);
    check("rst_hi_seg", ifb.seg, 8'h00);
    check("rst_hi_sel", {4'h0, ifb.sel}, 8'h00);

    rst_n = 1'b1;
    j = 0;
    pulse(4'd1, 4'd2, 4'd3, 4'd4);   // captured mid slot 0
    lit("blank0", 8'hFF, 4'hF);
    goto_j(3);  lit("unit0", 8'hC0, 4'hE);
    check("unit0_hi", ifb.seg, 8'h3F);
    goto_j(11); lit("tens3", 8'hB0, 4'hD);
    goto_j(19); lit("hund2", 8'hA4, 4'hB);
    goto_j(27); lit("thou1", 8'hF9, 4'h7);
    goto_j(33); lit("blank4", 8'hFF, 4'hF);
    goto_j(35); lit("unit4", 8'h99, 4'hE);

    goto_j(36);
    lz = 1'b1;
    pulse(4'd0, 4'd0, 4'd4, 4'd0);
    {thou, hund, tens, unit} = {4'd9, 4'd9, 4'd9, 4'd9};  // no strobe: ignored
    goto_j(44); lit("lz_tens", 8'h99, 4'hD);
    goto_j(52); lit("lz_hund", 8'hFF, 4'hB);
    goto_j(60); lit("lz_thou", 8'hFF, 4'h7);
    goto_j(68); lit("lz_unit", 8'hC0, 4'hE);

    lz = 1'b0;
    dp_en = 4'b0001;
    pulse(4'd0, 4'd0, 4'd4, 4'hC);
    unit = 4'd7;
    goto_j(76);  lit("dp_tens", 8'h99, 4'hD);
    goto_j(100); lit("dash_dp", 8'h3F, 4'hE);

    goto_j(111);                      // next edge is the slot wrap
    pulse(4'd5, 4'd6, 4'd7, 4'd8);
    goto_j(116); lit("wrap_hund", 8'h82, 4'hB);
    goto_j(124); lit("wrap_thou", 8'h92, 4'h7);

    repeat (800) begin
      tran_done = ($urandom_range(0, 4) == 0);
      thou  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      hund  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tens  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      unit  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dp_en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) lz = ~lz;
      step(1);
    end
    tran_done = 1'b0;
    dp_en = 4'd0;
    lz = 1'b0;

    // reset in the middle of the hund slot
    while (!(((j - 1) / DIV) % 4 == 2 && (j - 1) % DIV == 4)) step(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi_seg", ifb.seg, 8'h00);
    check("arst_hi_sel", {4'h0, ifb.sel}, 8'h00);
    lit("arst_lo", 8'hFF, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    j = 0;
    goto_j(3);
    check("rst_unit_hi_seg", ifb.seg, 8'h3F);
    check("rst_unit_hi_sel", {4'h0, ifb.sel}, 8'h01);
    goto_j(11);
    check("rst_tens_hi_sel", {4'h0, ifb.sel}, 8'h02);
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
